// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared types and constants for the ARM-subset pipeline
package arm_pipe_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'hE1A0_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DROP,
        ST_BUFFERED
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry skid buffer holding a fetched word across a stall
module fetch_skid_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        valid
);

    // Clear takes priority so a redirect always empties the entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            dout  <= din;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC, instruction fetch handshake and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_stage
    import arm_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    fetch_state_t state, state_n;
    logic [31:0]  fetch_addr, fetch_addr_n;
    logic [31:0]  redirect_addr, redirect_addr_n;
    logic [31:0]  instr_n, pc_n;
    logic         valid_n;
    logic         skid_load, skid_clear, skid_valid;
    logic [31:0]  skid_data;

    fetch_skid_buf u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .din   (imem_rdata),
        .dout  (skid_data),
        .valid (skid_valid)
    );

    assign imem_req  = (state == ST_FETCH) || (state == ST_DROP);
    assign imem_addr = fetch_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            fetch_addr    <= RESET_PC;
            redirect_addr <= RESET_PC;
            if_id_instr   <= NOP_INSTR;
            if_id_pc      <= '0;
            if_id_valid   <= 1'b0;
        end else begin
            state         <= state_n;
            fetch_addr    <= fetch_addr_n;
            redirect_addr <= redirect_addr_n;
            if_id_instr   <= instr_n;
            if_id_pc      <= pc_n;
            if_id_valid   <= valid_n;
        end
    end

    always_comb begin
        state_n         = state;
        fetch_addr_n    = fetch_addr;
        redirect_addr_n = redirect_addr;
        instr_n         = if_id_instr;
        pc_n            = if_id_pc;
        // A stalled decode keeps its instruction; otherwise IF/ID drains to a bubble.
        valid_n         = stall ? if_id_valid : 1'b0;
        skid_load       = 1'b0;
        skid_clear      = 1'b0;

        if (branch_taken) begin
            instr_n    = NOP_INSTR;
            pc_n       = '0;
            valid_n    = 1'b0;
            skid_clear = 1'b1;
            // An access still in flight must complete at its old address before redirecting.
            if ((state == ST_FETCH || state == ST_DROP) && !imem_ready) begin
                redirect_addr_n = branch_target;
                state_n         = ST_DROP;
            end else begin
                fetch_addr_n = branch_target;
                state_n      = ST_FETCH;
            end
        end else begin
            case (state)
                ST_IDLE: state_n = ST_FETCH;
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (stall) begin
                            skid_load = 1'b1;
                            state_n   = ST_BUFFERED;
                        end else begin
                            instr_n      = imem_rdata;
                            pc_n         = fetch_addr + WORD_BYTES;
                            valid_n      = 1'b1;
                            fetch_addr_n = fetch_addr + WORD_BYTES;
                        end
                    end
                end
                ST_DROP: begin
                    if (imem_ready) begin
                        fetch_addr_n = redirect_addr;
                        state_n      = ST_FETCH;
                    end
                end
                ST_BUFFERED: begin
                    if (!stall) begin
                        instr_n      = skid_data;
                        pc_n         = fetch_addr + WORD_BYTES;
                        valid_n      = skid_valid;
                        fetch_addr_n = fetch_addr + WORD_BYTES;
                        skid_clear   = 1'b1;
                        state_n      = ST_FETCH;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic if_id_load;
    assign if_id_load = !branch_taken && !stall &&
                        ((state == ST_FETCH && imem_ready) || state == ST_BUFFERED);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (if_id_load)
                perf_fetched <= perf_fetched + 32'd1;
            if (state != ST_IDLE && !if_id_valid)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`else
    // Counters and their ports are absent in this build.
`endif

endmodule
